// File: rtl/imem_loader.sv
// Packs little-endian bytes into N-bit words and writes them to imem from address 0, holding the CPU in reset.
// Start->RECV in 1 cycle, word write 1 cycle after its last byte; in_ready is low outside RECV, no timeout.
module imem_loader #(
    parameter int N  = 32,
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW:0]   len,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [N-1:0]  mem_wdata,
    output logic          cpu_reset,
    output logic          busy,
    output logic          done,
    output logic          err
);
    localparam int BPW   = N / 8;
    localparam int BCW   = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int DEPTH = 1 << AW;

    typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

    state_t         state;
    logic [BCW-1:0] byte_cnt;
    logic [AW-1:0]  word_addr;
    logic [AW:0]    len_q;
    logic [N-1:0]   asm_word;
    logic           len_ok;

    assign len_ok    = (len != '0) && (int'(len) <= DEPTH);
    assign mem_addr  = word_addr;
    assign mem_wdata = asm_word;

    // Outputs are registered alongside the state they belong to.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            byte_cnt  <= '0;
            word_addr <= '0;
            len_q     <= '0;
            asm_word  <= '0;
            in_ready  <= 1'b0;
            mem_we    <= 1'b0;
            cpu_reset <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            err    <= 1'b0;
            mem_we <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        if (len_ok) begin
                            state     <= RECV;
                            len_q     <= len;
                            word_addr <= '0;
                            byte_cnt  <= '0;
                            in_ready  <= 1'b1;
                            busy      <= 1'b1;
                            cpu_reset <= 1'b1;
                            done      <= 1'b0;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                RECV: begin
                    if (in_valid) begin
                        for (int k = 0; k < BPW; k++) begin
                            if (byte_cnt == BCW'(k)) asm_word[8*k +: 8] <= in_data;
                        end
                        if (byte_cnt == BCW'(BPW - 1)) begin
                            byte_cnt <= '0;
                            state    <= WRITE;
                            in_ready <= 1'b0;
                            mem_we   <= 1'b1;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end
                end
                WRITE: begin
                    // len_q is at least 1, so the subtraction cannot underflow.
                    if ({1'b0, word_addr} == len_q - 1'b1) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        cpu_reset <= 1'b0;
                    end else begin
                        word_addr <= word_addr + 1'b1;
                        state     <= RECV;
                        in_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// Directed sequence with random gaps/data, checked against a word-list model of the expected memory image.
module tb_imem_loader;
    localparam int N   = 32;
    localparam int AW  = 6;
    localparam int BPW = N / 8;

    logic          clk = 1'b0;
    logic          reset, start, in_valid;
    logic [AW:0]   len;
    logic [7:0]    in_data;
    logic          in_ready, mem_we, cpu_reset, busy, done, err;
    logic [AW-1:0] mem_addr;
    logic [N-1:0]  mem_wdata;

    int n_tests = 0;
    int n_fail  = 0;
    logic [N-1:0]    exp_words[$];
    logic [AW+N-1:0] wr_q[$];

    always #5 clk = ~clk;

    imem_loader #(.N(N), .AW(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .len(len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_reset(cpu_reset), .busy(busy), .done(done), .err(err)
    );

    task automatic chk1(input string tag, input logic obs, input logic expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    task automatic chkv(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Every memory write is captured; in_ready must be low while writing.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wr_q.push_back({mem_addr, mem_wdata});
            chk1("we_in_ready", in_ready, 1'b0);
        end
    end

    task automatic idle_outs(input string tag);
        chk1({tag, "_in_ready"}, in_ready, 1'b0);
        chk1({tag, "_mem_we"}, mem_we, 1'b0);
        chk1({tag, "_cpu_reset"}, cpu_reset, 1'b1);
        chk1({tag, "_busy"}, busy, 1'b0);
        chk1({tag, "_done"}, done, 1'b0);
    endtask

    // gap < 0: random idle cycles before the byte; otherwise a fixed count.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int t = 0;
        int g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
        in_valid = 1'b0;
        repeat (g) step();
        in_valid = 1'b1;
        in_data  = b;
        while (in_ready !== 1'b1 && t < 50) begin
            step();
            t++;
        end
        if (t >= 50) chk1("in_ready_timeout", in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic do_load(input int l, input int gap, input int poke_at);
        logic [N-1:0] w;
        wr_q.delete();
        start = 1'b1;
        len   = 7'(l);
        step();
        start = 1'b0;
        len   = 7'($urandom);
        chk1("acc_in_ready", in_ready, 1'b1);
        chk1("acc_busy", busy, 1'b1);
        chk1("acc_cpu_reset", cpu_reset, 1'b1);
        chk1("acc_done", done, 1'b0);
        for (int i = 0; i < l; i++) begin
            w = exp_words[i];
            for (int k = 0; k < BPW; k++) begin
                if (i == poke_at && k == 1) begin
                    start = 1'b1;
                    len   = 7'd2;
                end
                send_byte(w[8*k +: 8], gap);
                start = 1'b0;
                if (k == BPW - 1) chk1("we_latency", mem_we, 1'b1);
                else              chk1("no_early_we", mem_we, 1'b0);
            end
        end
        step();
        chk1("done_done", done, 1'b1);
        chk1("done_cpu_reset", cpu_reset, 1'b0);
        chk1("done_busy", busy, 1'b0);
        chk1("done_in_ready", in_ready, 1'b0);
        chkv("write_count", 64'(wr_q.size()), 64'(l));
        for (int i = 0; i < wr_q.size() && i < l; i++) begin
            chkv("write_addr", 64'(wr_q[i][AW+N-1:N]), 64'(i));
            chkv("write_data", 64'(wr_q[i][N-1:0]), 64'(exp_words[i]));
        end
    endtask

    task automatic reject(input int l, input logic in_done);
        wr_q.delete();
        start = 1'b1;
        len   = 7'(l);
        step();
        start = 1'b0;
        chk1("rej_err", err, 1'b1);
        chk1("rej_busy", busy, 1'b0);
        chk1("rej_cpu_reset", cpu_reset, !in_done);
        chk1("rej_done", done, in_done);
        step();
        chk1("rej_err_pulse", err, 1'b0);
        chk1("rej_state_kept", done, in_done);
        chkv("rej_no_write", 64'(wr_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b1; in_valid = 1'b1; len = 7'd1; in_data = 8'h55;
        repeat (3) begin
            step();
            idle_outs("rst");
            chk1("rst_err", err, 1'b0);
            chkv("rst_addr", 64'(mem_addr), 64'd0);
            chkv("rst_wdata", 64'(mem_wdata), 64'd0);
        end
        reset = 1'b0; start = 1'b0; in_valid = 1'b0;
        wr_q.delete();
        repeat (3) begin
            step();
            idle_outs("idle");
            chk1("idle_err", err, 1'b0);
        end

        reject(0, 1'b0);
        reject(65, 1'b0);
        idle_outs("post_reject");

        exp_words = '{32'h91003c0a};
        do_load(1, 0, -1);
        reject(0, 1'b1);
        reject(65, 1'b1);

        exp_words = '{32'haa14018b, 32'h8a14018c, 32'h8b0a0000};
        do_load(3, 1, -1);

        exp_words.delete();
        repeat (5) exp_words.push_back(N'($urandom));
        do_load(5, -1, -1);

        // Reset after 2 words and 2 bytes of a 4-word load.
        wr_q.delete();
        exp_words.delete();
        repeat (4) exp_words.push_back(N'($urandom));
        start = 1'b1; len = 7'd4;
        step();
        start = 1'b0;
        for (int b = 0; b < 2 * BPW + 2; b++) begin
            send_byte(exp_words[b / BPW][8*(b % BPW) +: 8], -1);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        idle_outs("midrst");
        chkv("midrst_writes", 64'(wr_q.size()), 64'd2);
        exp_words.delete();
        exp_words.push_back(N'($urandom));
        do_load(1, -1, -1);

        exp_words.delete();
        for (int i = 0; i < 64; i++) exp_words.push_back({8'(i + 3), 8'(i + 2), 8'(i + 1), 8'(i)});
        do_load(64, 0, 10);

        exp_words.delete();
        repeat (2) exp_words.push_back(N'($urandom));
        do_load(2, -1, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time sequencer that fills the writable instruction memory of the single-cycle processor from a byte-serial stream and holds the CPU in reset until loading completes. It accepts little-endian bytes over a valid/ready handshake and packs them into N-bit instruction words. It writes each word to consecutive instruction addresses starting at 0, then releases the core. A later start request reloads the memory.

## Interface
Parameters:
- N, 32, instruction word width; must be a multiple of 8; BPW = N/8 bytes per word
- AW, 6, instruction address width; memory depth 2^AW words

Ports:
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  request to begin a load; sampled only in IDLE and DONE
- len  in  AW+1  number of words to load; sampled on the cycle start is accepted
- in_valid  in  1  byte source has a byte on in_data
- in_data  in  8  byte from the source
- in_ready  out  1  loader accepts a byte this cycle
- mem_we  out  1  instruction memory write enable
- mem_addr  out  AW  instruction memory write address
- mem_wdata  out  N  instruction memory write data
- cpu_reset  out  1  holds the processor in reset while high
- busy  out  1  a load is in progress (RECV or WRITE)
- done  out  1  load completed; memory image valid
- err  out  1  one-cycle pulse: start was rejected because len was invalid

## Operation
- States: IDLE, RECV, WRITE, DONE. Reset enters IDLE. Reset also clears byte_cnt, word_addr and the assembly register.
- IDLE:
  - cpu_reset=1; all other outputs are 0.
  - start with 1 ≤ len ≤ 2^AW: latch len, clear word_addr and byte_cnt, go to RECV.
  - start with len=0 or len>2^AW: stay in IDLE and assert err for 1 cycle.
- RECV:
  - in_ready=1, busy=1, cpu_reset=1.
  - A byte transfers when in_valid && in_ready.
  - Byte k of a word (k = byte_cnt, 0..BPW-1) goes into word bits [8k+7:8k], so the first byte is the LSB.
  - When the byte with byte_cnt=BPW-1 transfers, byte_cnt returns to 0 and the state goes to WRITE.
  - in_valid low: hold state; no timeout.
- WRITE:
  - mem_we=1 for exactly 1 cycle, with mem_addr=word_addr and mem_wdata = the assembled word. in_ready=0, busy=1.
  - If word_addr == len-1, go to DONE. Otherwise increment word_addr and go to RECV.
- DONE:
  - done=1, cpu_reset=0, in_ready=0.
  - start with a valid len reasserts cpu_reset and enters RECV for a full reload. Invalid len pulses err and stays in DONE.
- start in RECV or WRITE is ignored and does not pulse err.
- mem_addr holds word_addr and mem_wdata holds the assembly register when mem_we=0. Both are don't-care for the memory.
- Reset mid-load returns to IDLE with cpu_reset=1. Words already written are not cleared; the next load overwrites them from address 0.
- len = 2^AW: the last write goes to address 2^AW-1. word_addr never wraps past the last address.

## Timing
- Reset values: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_reset=1, busy=0, done=0, err=0.
- All outputs are decoded from registered state or counters. There is no combinational path from in_valid, start or len to any output.
- Accepted start: RECV, with in_ready=1, on the next cycle.
- Write latency: mem_we is high in the cycle after the last byte of a word transfers.
- Throughput: at most 1 word per BPW+1 cycles (5 cycles at N=32). in_ready is 0 during WRITE.
- Release: cpu_reset falls in the cycle after the final WRITE cycle, the same cycle done rises.
- err is high in the cycle after the rejected start.

## Test plan
- Reset: hold reset 3 cycles with in_valid=1 and start=1 -> all outputs at reset values and state stays IDLE; after release, IDLE outputs hold until a valid start.
- Single word: start with len=1, then bytes 0x0a, 0x3c, 0x00, 0x91 on consecutive cycles -> exactly one mem_we pulse with addr 0 and data 0x91003c0a one cycle after the 4th byte; next cycle done=1 and cpu_reset=0.
- Multi-word with gaps: len=3, in_valid toggling every other cycle, words 0xaa14018b, 0x8a14018c, 0x8b0a0000 -> writes to addrs 0, 1, 2 in order with those values; no byte is lost or duplicated; in_ready=0 during each WRITE.
- Invalid length: start with len=0, then with len=65 (AW=6) -> one err pulse each, state stays IDLE, no mem_we, cpu_reset stays 1.
- Reset mid-load: len=4, assert reset after 2 words and 2 bytes -> IDLE next cycle with cpu_reset=1 and busy=0. A following len=1 load writes addr 0 and sees a fresh byte_cnt.
- Full depth and reload: len=64 with incrementing data -> last write at addr 63, then done. A start pulse during RECV is ignored. A start with len=2 from DONE reasserts cpu_reset, clears done, and rewrites addrs 0-1.
